cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 4-bit lookahead carry generator used in the datapath. WIDTH and group size are generic, a valid/ready handshake paces it, and a carry link register chains multi-word (double-precision) add/subtract across consecutive operations. It sits between the AR/BR operand registers and the AD result mux, and serves both single-word and double-word arithmetic sequences.

---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_group.sv | 45 ++++
 rtl/cla_pipe_adder.sv | 171 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared types and elaboration helpers for the pipelined
// carry-lookahead adder.
//   op_t      - ADD / SUB operation select
//   ngroups() - number of lookahead groups for a WIDTH/GROUP pair
//   width_ok()- legal-configuration check used at elaboration
package cla_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_t;

   function automatic int ngroups(input int width, input int group);
      return width / group;
   endfunction

   // The second level needs at least two groups so that the group carry
   // chain has an interior link; WIDTH must split evenly into groups.
   function automatic bit width_ok(input int width, input int group);
      return (group > 0) && (width % group == 0) && (width / group >= 2);
   endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: generalised N-bit carry-lookahead unit.
//   g, p : per-position generate / propagate (active-high)
//   cin  : carry into position 0
//   c    : c[i] = carry out of position i
//   gg   : group generate (carry out with cin=0)
//   gp   : group propagate (all positions propagate)
// Used both per bit-group and as the second level across groups.
module cla_group #(
   parameter int N = 4
) (
   input  logic [N-1:0] g,
   input  logic [N-1:0] p,
   input  logic         cin,
   output logic [N-1:0] c,
   output logic         gg,
   output logic         gp
);

   // Flat sum-of-products lookahead for the carry out of position msb:
   // g[msb] | p[msb]g[msb-1] | ... | p[msb..0]cin.
   function automatic logic lookahead(input logic [N-1:0] gv,
                                      input logic [N-1:0] pv,
                                      input logic         ci,
                                      input int           msb);
      logic acc;
      logic pp;
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = N - 1; j >= 0; j--) begin
         if (j <= msb) begin
            acc = acc | (pp & gv[j]);
            pp  = pp & pv[j];
         end
      end
      return acc | (pp & ci);
   endfunction

   for (genvar i = 0; i < N; i++) begin : g_carry
      assign c[i] = lookahead(g, p, cin, i);
   end

   assign gg = lookahead(g, p, 1'b0, N - 1);
   assign gp = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshake and a carry link register for multi-word chains.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - operation handshake into stage 1
//   a, b, op            - operands and ADD/SUB select
//   chain_in            - take carry-in from the link register
//   chain_out           - write this op's carry-out into the link register
//   out_valid/out_ready - result handshake out of stage 2
//   sum, cout, ovf, zero- registered result and flags
//   link                - current link register value
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   input  logic             chain_in,
   input  logic             chain_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             link
);

   localparam int NG     = ngroups(WIDTH, GROUP);
   localparam int STAGES = 2;

   if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP with at least two groups");
   end

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;          // already inverted for SUB
      op_t              op;
      logic             chain_in;
      logic             chain_out;
      logic [NG-1:0]    gg;
      logic [NG-1:0]    gp;
   } s1_t;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
   } s2_t;

   localparam s2_t S2_RST = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b1};

   logic [STAGES:1] vld_pipe;
   s1_t             s1_d, s1_q;
   s2_t             s2_d, s2_q;
   logic            link_q;
   logic            accept, s1_adv;
   logic [WIDTH-1:0] beff;

   // ---------------------------------------------------------------- S1
   // Group generate/propagate from the raw operands; inclusive propagate
   // (a|b) is enough for carries, the sum XOR is rebuilt in S2.
   function automatic logic [1:0] grp_gp(input logic [GROUP-1:0] av,
                                         input logic [GROUP-1:0] bv);
      logic gacc;
      logic pacc;
      gacc = 1'b0;
      pacc = 1'b1;
      for (int k = 0; k < GROUP; k++) begin
         gacc = (av[k] & bv[k]) | ((av[k] | bv[k]) & gacc);
         pacc = pacc & (av[k] | bv[k]);
      end
      return {gacc, pacc};
   endfunction

   assign beff = (op == SUB) ? ~b : b;

   always_comb begin
      s1_d           = '0;
      s1_d.a         = a;
      s1_d.b         = beff;
      s1_d.op        = op;
      s1_d.chain_in  = chain_in;
      s1_d.chain_out = chain_out;
      for (int j = 0; j < NG; j++) begin
         {s1_d.gg[j], s1_d.gp[j]} = grp_gp(a[j*GROUP +: GROUP], beff[j*GROUP +: GROUP]);
      end
   end

   // ---------------------------------------------------------------- S2
   logic             cin2;
   logic [NG-1:0]    gc;
   logic [NG-1:0]    cchain;
   logic [WIDTH-1:0] bg, bp, bc, cbit;
   logic             lvl2_gg_unused, lvl2_gp_unused;
   logic [NG-1:0]    grp_gg_unused, grp_gp_unused;

   // Link is already updated by a chained predecessor: it left S1 at least
   // one edge before this op can.
   assign cin2   = s1_q.chain_in ? link_q : (s1_q.op == SUB);
   assign bg     = s1_q.a & s1_q.b;
   assign bp     = s1_q.a | s1_q.b;
   assign cchain = {gc[NG-2:0], cin2};   // carry into each group
   assign cbit   = {bc[WIDTH-2:0], cin2}; // carry into each bit

   cla_group #(.N(NG)) u_lvl2 (
      .g   (s1_q.gg),
      .p   (s1_q.gp),
      .cin (cin2),
      .c   (gc),
      .gg  (lvl2_gg_unused),
      .gp  (lvl2_gp_unused)
   );

   for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.N(GROUP)) u_grp (
         .g   (bg[j*GROUP +: GROUP]),
         .p   (bp[j*GROUP +: GROUP]),
         .cin (cchain[j]),
         .c   (bc[j*GROUP +: GROUP]),
         .gg  (grp_gg_unused[j]),
         .gp  (grp_gp_unused[j])
      );
   end

   always_comb begin
      s2_d      = S2_RST;
      s2_d.sum  = s1_q.a ^ s1_q.b ^ cbit;
      s2_d.cout = gc[NG-1];
      s2_d.ovf  = cbit[WIDTH-1] ^ bc[WIDTH-1];
      s2_d.zero = ~|s2_d.sum;
   end

   // --------------------------------------------------------- handshake
   assign s1_adv   = vld_pipe[1] & (~vld_pipe[2] | out_ready);
   assign in_ready = ~vld_pipe[1] | s1_adv;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= S2_RST;
         link_q   <= 1'b0;
      end else begin
         if (accept) s1_q <= s1_d;
         if (s1_adv) begin
            s2_q <= s2_d;
            if (s1_q.chain_out) link_q <= s2_d.cout;
         end
         vld_pipe[1] <= accept | (vld_pipe[1] & ~s1_adv);
         vld_pipe[2] <= s1_adv | (vld_pipe[2] & ~out_ready);
      end
   end

   assign out_valid = vld_pipe[2];
   assign sum       = s2_q.sum;
   assign cout      = s2_q.cout;
   assign ovf       = s2_q.ovf;
   assign zero      = s2_q.zero;
   assign link      = link_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder (WIDTH=36, GROUP=4): scoreboard of expected
// results filled at acceptance, drained by a result monitor.
module tb_cla_pipe_adder;
   import cla_pkg::*;

   localparam int W = 36;
   localparam int G = 4;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, chain_in, chain_out;
   logic         out_valid, out_ready, cout, ovf, zero, link;
   logic [W-1:0] a, b, sum;
   op_t          op;

   cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .chain_in(chain_in), .chain_out(chain_out),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
      .ovf(ovf), .zero(zero), .link(link)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   res_t sb[$];
   int   nchk = 0;
   int   nfail = 0;
   int   cyc = 0;
   logic m_link = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Result monitor: a transfer happens at the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         res_t got, exp;
         got = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
         nchk++;
         if (sb.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b zero=%b, required no result",
                     sum, cout, ovf, zero);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               nfail++;
               $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b, required sum=%h cout=%b ovf=%b zero=%b",
                        got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // Drive one op starting at posedge+1; returns at posedge+1 after accept.
   task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input op_t o, input logic ci, input logic co);
      res_t         r;
      logic [W-1:0] be;
      logic [W:0]   full;
      logic         c0, rdy;
      int           t;
      be   = (o == SUB) ? ~bi : bi;
      c0   = ci ? m_link : (o == SUB);
      full = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, c0};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (ai[W-1] == be[W-1]) && (r.sum[W-1] != ai[W-1]);
      r.zero = (r.sum == '0);
      in_valid = 1'b1; a = ai; b = bi; op = o; chain_in = ci; chain_out = co;
      t = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 200);
      in_valid = 1'b0;
      if (!rdy) begin
         nchk++; nfail++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", t);
      end else begin
         sb.push_back(r);
         if (co) m_link = r.cout;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (sb.size() != 0) begin
         nchk++; nfail++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = ADD; chain_in = 1'b0; chain_out = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      nchk++; if (in_ready !== 1'b1)  begin nfail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
      nchk++; if (link !== 1'b0)      begin nfail++; $display("FAIL rst_link: got %b required 0", link); end
      nchk++; if (zero !== 1'b1)      begin nfail++; $display("FAIL rst_zero: got %b required 1", zero); end
      nchk++; if ({sum, cout, ovf} !== {{W{1'b0}}, 2'b00}) begin
         nfail++; $display("FAIL rst_sum_flags: got sum=%h cout=%b ovf=%b required zeros", sum, cout, ovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(36'o377777777777, 36'd1, ADD, 1'b0, 1'b0);
      @(negedge clk);
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL latency_early: got out_valid=%b required 0", out_valid); end
      @(negedge clk);
      nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL latency_due: got out_valid=%b required 1", out_valid); end
      @(posedge clk);
      #1;
      send(36'd5, 36'd5, SUB, 1'b0, 1'b0);
      send(36'd3, 36'd5, SUB, 1'b0, 1'b0);
      send(36'o400000000000, 36'd1, SUB, 1'b0, 1'b0);
      wait_drain();
   endtask

   task automatic test_chain();
      out_ready = 1'b1;
      send(36'o777777777777, 36'd1, ADD, 1'b0, 1'b1);
      send(36'd0, 36'd0, ADD, 1'b1, 1'b0);
      wait_drain();
      nchk++; if (link !== 1'b1) begin nfail++; $display("FAIL chain_link: got %b required 1", link); end
      send(36'd3, 36'd4, ADD, 1'b0, 1'b0);
      wait_drain();
      nchk++; if (link !== 1'b1) begin nfail++; $display("FAIL link_hold: got %b required 1", link); end
      // Double-word subtract 0x1_0 - 0x0_1: low borrows, high consumes it.
      send(36'd0, 36'd1, SUB, 1'b0, 1'b1);
      send(36'd1, 36'd0, SUB, 1'b1, 1'b1);
      wait_drain();
      nchk++; if (link !== 1'b1) begin nfail++; $display("FAIL sub_chain_link: got %b required 1", link); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(W'(100 + i), 36'd1, ADD, 1'b0, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
               nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
               nchk++; if (sum !== 36'd101) begin nfail++; $display("FAIL bp_sum_hold: got %h required %h", sum, 36'd101); end
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int c0;
      out_ready = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 16; i++) send(W'($urandom) << 4 | W'(i), W'($urandom), op_t'(i & 1), 1'b0, 1'b0);
      nchk++; if (cyc - c0 != 16) begin nfail++; $display("FAIL throughput: got %0d cycles required 16", cyc - c0); end
      wait_drain();
   endtask

   task automatic test_midreset();
      out_ready = 1'b1;
      send(36'o777777777777, 36'd1, ADD, 1'b0, 1'b1);
      wait_drain();
      nchk++; if (link !== 1'b1) begin nfail++; $display("FAIL pre_reset_link: got %b required 1", link); end
      out_ready = 1'b0;
      send(36'd7, 36'd8, ADD, 1'b0, 1'b0);
      send(36'd9, 36'd1, ADD, 1'b0, 1'b0);
      @(negedge clk);
      nchk++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      m_link = 1'b0;
      @(negedge clk);
      nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
      nchk++; if (in_ready !== 1'b1)  begin nfail++; $display("FAIL mid_rst_in_ready: got %b required 1", in_ready); end
      nchk++; if (link !== 1'b0)      begin nfail++; $display("FAIL mid_rst_link: got %b required 0", link); end
      nchk++; if (zero !== 1'b1)      begin nfail++; $display("FAIL mid_rst_zero: got %b required 1", zero); end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(36'd0, 36'd0, ADD, 1'b1, 1'b0);
      send(36'd5, 36'd3, SUB, 1'b1, 1'b0);
      wait_drain();
   endtask

   task automatic test_random();
      bit done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 3000; i++) begin
               logic [W-1:0] ra, rb;
               int           sel;
               sel = $urandom_range(0, 7);
               ra  = (sel == 0) ? '1 : (sel == 1) ? '0 : {W'($urandom), 4'h0} ^ W'($urandom);
               rb  = (sel == 2) ? '1 : (sel == 3) ? W'(1) : {W'($urandom), 4'h0} ^ W'($urandom);
               if ($urandom_range(0, 7) == 0) begin
                  // Garbage on the inputs with in_valid low must be ignored.
                  in_valid = 1'b0; a = '1; b = '1; op = SUB; chain_out = 1'b1;
                  @(posedge clk);
                  #1;
               end
               send(ra, rb, op_t'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
      a = '0; b = '0; op = ADD; chain_in = 1'b0; chain_out = 1'b0;
      test_reset();
      test_basic();
      test_chain();
      test_backpressure();
      test_back_to_back();
      test_midreset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
